// File: rtl/wdog_timer.sv
// Two-stage watchdog: the first expiry raises an interrupt, and a second unserviced expiry
// drives a fixed-length reset request. Registers are reached through a lockable write port.
module wdog_timer #(
    parameter int          CNT_W      = 32,
    parameter int          PRESCALE   = 1,
    parameter int          RST_PULSE  = 4,
    parameter logic [31:0] UNLOCK_KEY = 32'h1ACCE551
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        wr_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        wdog_int,
    output logic        watchdog_reset
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(RST_PULSE - 1);

    typedef enum logic {S_RUN, S_PULSE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_load, w_load_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_inten, w_inten_nxt;
    logic             r_resen, w_resen_nxt;
    logic             r_int_pend, w_int_pend_nxt;
    logic             r_locked, w_locked_nxt;
    logic [PS_W-1:0]  r_presc, w_presc_nxt;
    logic [PC_W-1:0]  r_pcnt, w_pcnt_nxt;
    logic [31:0]      r_rdata, w_rdata;
    logic             r_wdog_int;

    logic w_wr_ok, w_kick, w_ld_wr, w_reload, w_tick;

    // LOCK stays writable so software can always unlock.
    assign w_wr_ok  = wr_en && (!r_locked || addr == 3'd4);
    assign w_kick   = w_wr_ok && addr == 3'd3;
    assign w_ld_wr  = w_wr_ok && addr == 3'd0;
    assign w_reload = w_kick || w_ld_wr;
    assign w_tick   = (r_state == S_RUN) && r_inten && (r_presc == PS_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_load_nxt     = r_load;
        w_count_nxt    = r_count;
        w_inten_nxt    = r_inten;
        w_resen_nxt    = r_resen;
        w_int_pend_nxt = r_int_pend;
        w_locked_nxt   = r_locked;
        w_presc_nxt    = r_presc;
        w_pcnt_nxt     = r_pcnt;
        case (r_state)
            S_RUN: begin
                if (r_inten)
                    w_presc_nxt = (r_presc == PS_MAX) ? '0 : r_presc + PS_W'(1);
                // A reload on the same edge wins over expiry and decrement.
                if (w_tick && !w_reload) begin
                    if (r_count != '0) begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end else begin
                        w_count_nxt = r_load;
                        if (!r_int_pend) begin
                            w_int_pend_nxt = 1'b1;
                        end else if (r_resen) begin
                            w_state_nxt = S_PULSE;
                            w_pcnt_nxt  = PC_MAX;
                        end
                    end
                end
            end
            S_PULSE: begin
                if (r_pcnt == '0) begin
                    w_state_nxt    = S_RUN;
                    w_int_pend_nxt = 1'b0;
                    w_presc_nxt    = '0;
                end else begin
                    w_pcnt_nxt = r_pcnt - PC_W'(1);
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
        if (w_ld_wr) begin
            w_load_nxt  = wdata[CNT_W-1:0];
            w_count_nxt = wdata[CNT_W-1:0];
            w_presc_nxt = '0;
        end
        if (w_kick) begin
            w_int_pend_nxt = 1'b0;
            w_count_nxt    = r_load;
            w_presc_nxt    = '0;
        end
        if (w_wr_ok && addr == 3'd2) begin
            w_inten_nxt = wdata[0];
            w_resen_nxt = wdata[1];
        end
        if (wr_en && addr == 3'd4)
            w_locked_nxt = (wdata != UNLOCK_KEY);
    end

    always_comb begin
        w_rdata = '0;
        case (addr)
            3'd0:    w_rdata = 32'(r_load);
            3'd1:    w_rdata = 32'(r_count);
            3'd2:    w_rdata = {30'b0, r_resen, r_inten};
            3'd4:    w_rdata = {31'b0, r_locked};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= S_RUN;
            r_load     <= '1;
            r_count    <= '1;
            r_inten    <= 1'b0;
            r_resen    <= 1'b0;
            r_int_pend <= 1'b0;
            r_locked   <= 1'b0;
            r_presc    <= '0;
            r_pcnt     <= '0;
            r_rdata    <= '0;
            r_wdog_int <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_load     <= w_load_nxt;
            r_count    <= w_count_nxt;
            r_inten    <= w_inten_nxt;
            r_resen    <= w_resen_nxt;
            r_int_pend <= w_int_pend_nxt;
            r_locked   <= w_locked_nxt;
            r_presc    <= w_presc_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_rdata    <= w_rdata;
            r_wdog_int <= w_int_pend_nxt & w_inten_nxt;
        end
    end

    assign rdata          = r_rdata;
    assign wdog_int       = r_wdog_int;
    assign watchdog_reset = (r_state == S_PULSE);

endmodule

// File: tb/tb_wdog_timer.sv
// Bench for wdog_timer: two parameterisations driven from the same stimulus, each checked
// every cycle against a cycle-level reference model, plus directed scenarios with literal values.
module tb_wdog_timer;

    localparam logic [31:0] KEY = 32'h1ACCE551;

    logic        HCLK = 1'b0;
    logic        HRESET, wr_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        int_a, int_b, rst_a, rst_b;

    always #5 HCLK = ~HCLK;

    wdog_timer u_a (
        .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata_a), .wdog_int(int_a), .watchdog_reset(rst_a)
    );

    wdog_timer #(.CNT_W(8), .PRESCALE(3), .RST_PULSE(2)) u_b (
        .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata_b), .wdog_int(int_b), .watchdog_reset(rst_b)
    );

    typedef struct {
        logic [31:0] load, count, rd;
        bit          inten, resen, int_pend, locked, wint, wrst;
        int          presc, pulse_left;
    } mdl_t;

    mdl_t ma, mb;
    bit   chk_en = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    function automatic mdl_t mdl_reset(int cw);
        mdl_t m;
        m.load = (cw >= 32) ? 32'hFFFFFFFF : (32'd1 << cw) - 32'd1;
        m.count = m.load;
        m.rd = 0; m.inten = 0; m.resen = 0; m.int_pend = 0; m.locked = 0;
        m.wint = 0; m.wrst = 0; m.presc = 0; m.pulse_left = 0;
        return m;
    endfunction

    // One clock edge of behaviour; pulse_left is the number of reset-high cycles still owed.
    function automatic mdl_t mdl_step(mdl_t m, bit r, bit we, logic [2:0] a, logic [31:0] d,
                                      int cw, int ps, int rp);
        mdl_t n;
        logic [31:0] mask;
        bit reload;
        if (r) return mdl_reset(cw);
        n = m;
        mask = (cw >= 32) ? 32'hFFFFFFFF : (32'd1 << cw) - 32'd1;
        case (a)
            3'd0:    n.rd = m.load;
            3'd1:    n.rd = m.count;
            3'd2:    n.rd = {30'b0, m.resen, m.inten};
            3'd4:    n.rd = {31'b0, m.locked};
            default: n.rd = 0;
        endcase
        reload = we && !m.locked && (a == 3'd0 || a == 3'd3);
        if (m.pulse_left > 0) begin
            n.pulse_left = m.pulse_left - 1;
            if (n.pulse_left == 0) begin n.int_pend = 0; n.presc = 0; end
        end else if (m.inten) begin
            n.presc = (m.presc + 1) % ps;
            if (n.presc == 0 && !reload) begin
                if (m.count != 0) n.count = m.count - 1;
                else begin
                    n.count = m.load;
                    if (!m.int_pend) n.int_pend = 1;
                    else if (m.resen) n.pulse_left = rp;
                end
            end
        end
        if (we) begin
            case (a)
                3'd0: if (!m.locked) begin n.load = d & mask; n.count = d & mask; n.presc = 0; end
                3'd2: if (!m.locked) begin n.inten = d[0]; n.resen = d[1]; end
                3'd3: if (!m.locked) begin n.int_pend = 0; n.count = m.load; n.presc = 0; end
                3'd4: n.locked = (d != KEY);
                default: ;
            endcase
        end
        n.wint = n.int_pend && n.inten;
        n.wrst = n.pulse_left > 0;
        return n;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(bit r, bit we, logic [2:0] a, logic [31:0] d);
        HRESET = r; wr_en = we; addr = a; wdata = d;
        @(posedge HCLK);
        ma = mdl_step(ma, r, we, a, d, 32, 1, 4);
        mb = mdl_step(mb, r, we, a, d, 8, 3, 2);
        #2;
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("a_rdata", rdata_a, ma.rd);
            check("a_int", {31'b0, int_a}, {31'b0, ma.wint});
            check("a_rst", {31'b0, rst_a}, {31'b0, ma.wrst});
            check("b_rdata", rdata_b, mb.rd);
            check("b_int", {31'b0, int_b}, {31'b0, mb.wint});
            check("b_rst", {31'b0, rst_b}, {31'b0, mb.wrst});
        end
    end

    initial begin
        HRESET = 1'b1; wr_en = 1'b0; addr = '0; wdata = '0;
        ma = mdl_reset(32); mb = mdl_reset(8);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        check("reset_rdata", rdata_a, 32'h0);
        check("reset_wrst", {31'b0, rst_a}, 32'h0);
        cyc(0, 0, 0, 0);
        check("reset_load", rdata_a, 32'hFFFFFFFF);

        // Countdown: LOAD=5, CTRL=1
        cyc(0, 1, 0, 5); cyc(0, 1, 2, 1);
        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 1, 0);
            if (k >= 2 && k <= 6) check("count_value", rdata_a, 32'(6 - k));
            if (k == 5) check("int_before_expiry", {31'b0, int_a}, 32'h0);
            if (k == 6) check("int_after_expiry", {31'b0, int_a}, 32'h1);
            if (k == 7) check("count_reload", rdata_a, 32'd5);
        end

        // Escalation without service: LOAD=3, CTRL=3
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 3); cyc(0, 1, 2, 3);
        for (int k = 1; k <= 14; k++) begin
            cyc(0, 0, 1, 0);
            if (k == 4) check("esc_int", {31'b0, int_a}, 32'h1);
            if (k == 7) check("esc_rst_low", {31'b0, rst_a}, 32'h0);
            if (k >= 8 && k <= 11) check("esc_rst_high", {31'b0, rst_a}, 32'h1);
            if (k == 12) begin
                check("esc_rst_end", {31'b0, rst_a}, 32'h0);
                check("esc_int_clr", {31'b0, int_a}, 32'h0);
            end
            if (k == 14) check("esc_resume", rdata_a, 32'd2);
        end

        // Kick exactly on the escalating tick
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 3); cyc(0, 1, 2, 3);
        for (int k = 1; k <= 7; k++) cyc(0, 0, 1, 0);
        cyc(0, 1, 3, 0);
        check("kick_no_rst", {31'b0, rst_a}, 32'h0);
        check("kick_int", {31'b0, int_a}, 32'h0);
        cyc(0, 0, 1, 0);
        check("kick_value", rdata_a, 32'd3);

        // Mask and unmask a pending interrupt
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 1); cyc(0, 1, 2, 1);
        for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 0);
        check("pend_int", {31'b0, int_a}, 32'h1);
        cyc(0, 1, 2, 0);
        check("mask_int", {31'b0, int_a}, 32'h0);
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        check("mask_frozen", rdata_a, 32'd1);
        cyc(0, 1, 2, 1);
        check("unmask_int", {31'b0, int_a}, 32'h1);

        // HRESET during the second pulse cycle
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); cyc(0, 1, 2, 3);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1, 0);
            if (k >= 2) check("pulse_high", {31'b0, rst_a}, 32'h1);
        end
        cyc(1, 0, 0, 0);
        check("pulse_abort", {31'b0, rst_a}, 32'h0);
        check("abort_int", {31'b0, int_a}, 32'h0);
        cyc(0, 0, 0, 0);
        check("abort_load", rdata_a, 32'hFFFFFFFF);

        // Lock and unlock
        cyc(0, 1, 4, 0); cyc(0, 1, 0, 7);
        cyc(0, 0, 4, 0);
        check("lock_read", rdata_a, 32'h1);
        cyc(0, 0, 0, 0);
        check("locked_load", rdata_a, 32'hFFFFFFFF);
        cyc(0, 1, 4, KEY); cyc(0, 1, 0, 7);
        cyc(0, 0, 1, 0);
        check("unlock_value", rdata_a, 32'd7);
        cyc(0, 0, 4, 0);
        check("unlock_read", rdata_a, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            bit          r, we;
            logic [2:0]  a;
            logic [31:0] d;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 3) == 0);
            a  = 3'($urandom_range(0, 7));
            case (a)
                3'd0:    d = 32'($urandom_range(0, 6));
                3'd2:    d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd3;
                3'd4:    d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : KEY;
                default: d = 32'($urandom);
            endcase
            cyc(r, we, a, d);
        end

        @(negedge HCLK);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
